dataflow_deadlock_monitor: RTL and testbench

- Synthesizable, parametrised wait-for-graph deadlock monitor for HLS dataflow regions with N_PROC processes.
- Each process reports whether it is blocked and which process it is waiting on, via a FIFO or start-token handshake.
- The block detects a stable circular wait by pointer-chasing the graph over multiple cycles.
- It reports the cycle membership, length and origin. It sits beside a dataflow region and replaces the per-region simulation-only detectors.

---
 rtl/dataflow_deadlock_monitor_if.sv | 43 ++++
 rtl/dataflow_deadlock_monitor.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_dataflow_deadlock_monitor.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dataflow_deadlock_monitor_if.sv
// -----------------------------------------------------------------------------
// dataflow_deadlock_monitor_if
//   Groups the wait-for-graph inputs and the deadlock report of
//   dataflow_deadlock_monitor.
//
//   Signals:
//     proc_blk      [N_PROC]       bit i = process i is stalled on a channel
//     proc_dep_id   [N_PROC*ID_W]  slice i = id of the process i waits on
//     dl_clear                     pulse: clear sticky results, re-arm
//     busy                         monitor is walking or tracing the graph
//     dl_detect                    sticky: circular wait found
//     dl_origin     [ID_W]         first repeated node of the cycle
//     dl_cycle_mask [N_PROC]       processes forming the cycle
//     dl_cycle_len  [ID_W+1]       popcount of dl_cycle_mask
//     dl_timeout                   sticky watchdog flag
//
//   Modports: master drives the graph (dataflow region / bench),
//             slave is the monitor.
// -----------------------------------------------------------------------------
interface dataflow_deadlock_monitor_if #(
  parameter int N_PROC = 3,
  parameter int ID_W   = 2
);
  logic [N_PROC-1:0]      proc_blk;
  logic [N_PROC*ID_W-1:0] proc_dep_id;
  logic                   dl_clear;
  logic                   busy;
  logic                   dl_detect;
  logic [ID_W-1:0]        dl_origin;
  logic [N_PROC-1:0]      dl_cycle_mask;
  logic [ID_W:0]          dl_cycle_len;
  logic                   dl_timeout;

  modport master (
    output proc_blk, proc_dep_id, dl_clear,
    input  busy, dl_detect, dl_origin, dl_cycle_mask, dl_cycle_len, dl_timeout
  );

  modport slave (
    input  proc_blk, proc_dep_id, dl_clear,
    output busy, dl_detect, dl_origin, dl_cycle_mask, dl_cycle_len, dl_timeout
  );
endinterface

// File: rtl/dataflow_deadlock_monitor.sv
// -----------------------------------------------------------------------------
// dataflow_deadlock_monitor
//   Wait-for-graph deadlock monitor for an HLS dataflow region. Once the
//   blocked/dependency picture has been stable for STALL_CYCLES, the graph is
//   snapshotted and walked one node per cycle (WALK) from the lowest blocked
//   process. A chain reaching a running node restarts from the next untried
//   blocked process; revisiting a node marks a cycle, which is then traced
//   once around (TRACE) to build the membership mask. The result is sticky
//   until dl_clear.
//
//   Ports:
//     clock  system clock
//     reset  asynchronous active-low reset
//     mon    dataflow_deadlock_monitor_if.slave (graph in, report out)
//
//   Optional feature: define DL_TIMEOUT_EN to build a watchdog that sets the
//   sticky dl_timeout after TIMEOUT_CYCLES consecutive cycles with any
//   process blocked. Without it dl_timeout is tied to 0.
// -----------------------------------------------------------------------------
module dataflow_deadlock_monitor #(
  parameter int N_PROC         = 3,
  parameter int ID_W           = 2,
  parameter int STALL_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                        clock,
  input logic                        reset,
  dataflow_deadlock_monitor_if.slave mon
);

  generate
    if (N_PROC < 2 || N_PROC > 32 || (2 ** ID_W) < N_PROC ||
        STALL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("dataflow_deadlock_monitor: illegal parameter combination");
    end
  endgenerate

  localparam int SC_W = $clog2(STALL_CYCLES + 1);
  localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_CYCLES);

  typedef enum logic [1:0] {IDLE, WALK, TRACE, DONE} state_t;

  // ---------------------------------------------------------------------------
  // Helpers: index-free access so ids >= N_PROC never address past the vector.
  // ---------------------------------------------------------------------------
  function automatic logic [N_PROC-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_PROC-1:0] r;
    r = '0;
    for (int i = 0; i < N_PROC; i++)
      if (ID_W'(i) == idx) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [ID_W-1:0] dep_of(input logic [N_PROC*ID_W-1:0] deps,
                                             input logic [ID_W-1:0]        idx);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_PROC; i++)
      if (ID_W'(i) == idx) r = deps[i*ID_W +: ID_W];
    return r;
  endfunction

  function automatic logic [ID_W-1:0] lowest(input logic [N_PROC-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = N_PROC - 1; i >= 0; i--)
      if (v[i]) r = ID_W'(i);
    return r;
  endfunction

  function automatic logic [ID_W:0] popcount(input logic [N_PROC-1:0] v);
    logic [ID_W:0] r;
    r = '0;
    for (int i = 0; i < N_PROC; i++)
      r = r + (ID_W+1)'(v[i]);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state,        state_n;
  logic [N_PROC-1:0]      prev_blk;
  logic [N_PROC*ID_W-1:0] prev_dep;
  logic [SC_W-1:0]        stall_cnt,    stall_n;
  logic                   armed,        armed_n;
  logic [N_PROC-1:0]      snap_blk,     snap_blk_n;
  logic [N_PROC*ID_W-1:0] snap_dep,     snap_dep_n;
  logic [N_PROC-1:0]      tried,        tried_n;
  logic [ID_W-1:0]        walk_origin,  walk_origin_n;
  logic [ID_W-1:0]        cur,          cur_n;
  logic [N_PROC-1:0]      visited,      visited_n;
  logic [ID_W-1:0]        cyc_origin,   cyc_origin_n;
  logic [N_PROC-1:0]      cyc_mask,     cyc_mask_n;
  logic                   detect_q,     detect_n;
  logic [ID_W-1:0]        origin_q,     origin_n;
  logic [N_PROC-1:0]      mask_q,       mask_n;
  logic [ID_W:0]          len_q,        len_n;

  logic                   in_changed;
  logic                   snap_diff;
  logic [ID_W-1:0]        cur_dep;
  logic [N_PROC-1:0]      cur_oh;
  logic [N_PROC-1:0]      visited_all;
  logic [N_PROC-1:0]      tried_all;
  logic [N_PROC-1:0]      untried;
  logic                   chain_ends;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_n       = state;
    stall_n       = stall_cnt;
    armed_n       = armed;
    snap_blk_n    = snap_blk;
    snap_dep_n    = snap_dep;
    tried_n       = tried;
    walk_origin_n = walk_origin;
    cur_n         = cur;
    visited_n     = visited;
    cyc_origin_n  = cyc_origin;
    cyc_mask_n    = cyc_mask;
    detect_n      = detect_q;
    origin_n      = origin_q;
    mask_n        = mask_q;
    len_n         = len_q;

    in_changed  = (mon.proc_blk != prev_blk) || (mon.proc_dep_id != prev_dep);
    snap_diff   = (mon.proc_blk != snap_blk) || (mon.proc_dep_id != snap_dep);
    cur_dep     = dep_of(snap_dep, cur);
    cur_oh      = onehot(cur);
    visited_all = visited | cur_oh;
    tried_all   = tried | onehot(walk_origin);
    untried     = snap_blk & ~tried_all;
    chain_ends  = !(|(snap_blk & cur_oh)) || (int'(cur_dep) >= N_PROC);

    if (mon.proc_blk == '0 || in_changed) stall_n = '0;
    else if (stall_cnt != STALL_MAX)      stall_n = stall_cnt + SC_W'(1);

    // Any change in the graph is a new situation worth searching.
    if (in_changed) armed_n = 1'b1;

    unique case (state)
      IDLE: begin
        if (stall_cnt == STALL_MAX && !detect_q && armed) begin
          state_n       = WALK;
          // The registered copy is exactly the picture that was counted stable.
          snap_blk_n    = prev_blk;
          snap_dep_n    = prev_dep;
          tried_n       = '0;
          walk_origin_n = lowest(prev_blk);
          cur_n         = lowest(prev_blk);
          visited_n     = '0;
        end
      end

      WALK: begin
        if (snap_diff) begin
          state_n = IDLE;
          stall_n = '0;
        end else if (chain_ends) begin
          tried_n = tried_all;
          if (untried == '0) begin
            state_n = IDLE;
            if (!in_changed) armed_n = 1'b0;
          end else begin
            walk_origin_n = lowest(untried);
            cur_n         = lowest(untried);
            // Nodes of a dead chain must not look like a revisit later.
            visited_n     = '0;
          end
        end else if (|(visited_all & onehot(cur_dep))) begin
          visited_n    = visited_all;
          cyc_origin_n = cur_dep;
          cur_n        = cur_dep;
          cyc_mask_n   = '0;
          state_n      = TRACE;
        end else begin
          visited_n = visited_all;
          cur_n     = cur_dep;
        end
      end

      TRACE: begin
        if (snap_diff) begin
          state_n = IDLE;
          stall_n = '0;
        end else begin
          cyc_mask_n = cyc_mask | cur_oh;
          cur_n      = cur_dep;
          if (cur_dep == cyc_origin) begin
            detect_n = 1'b1;
            origin_n = cyc_origin;
            mask_n   = cyc_mask | cur_oh;
            len_n    = popcount(cyc_mask | cur_oh);
            state_n  = DONE;
          end
        end
      end

      DONE: ;

      default: state_n = IDLE;
    endcase

    // A clear overrides everything, including a walk starting this cycle.
    if (mon.dl_clear) begin
      state_n  = IDLE;
      armed_n  = 1'b1;
      stall_n  = '0;
      detect_n = 1'b0;
      origin_n = '0;
      mask_n   = '0;
      len_n    = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the snapshot and walk registers are reset too; they are small and a
  // defined reset image keeps the first abort comparison free of X.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prev_blk    <= '0;
      prev_dep    <= '0;
      stall_cnt   <= '0;
      armed       <= 1'b1;
      snap_blk    <= '0;
      snap_dep    <= '0;
      tried       <= '0;
      walk_origin <= '0;
      cur         <= '0;
      visited     <= '0;
      cyc_origin  <= '0;
      cyc_mask    <= '0;
      detect_q    <= 1'b0;
      origin_q    <= '0;
      mask_q      <= '0;
      len_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_n;
      prev_blk    <= mon.proc_blk;
      prev_dep    <= mon.proc_dep_id;
      stall_cnt   <= stall_n;
      armed       <= armed_n;
      snap_blk    <= snap_blk_n;
      snap_dep    <= snap_dep_n;
      tried       <= tried_n;
      walk_origin <= walk_origin_n;
      cur         <= cur_n;
      visited     <= visited_n;
      cyc_origin  <= cyc_origin_n;
      cyc_mask    <= cyc_mask_n;
      detect_q    <= detect_n;
      origin_q    <= origin_n;
      mask_q      <= mask_n;
      len_q       <= len_n;
    end
  end

  assign mon.busy          = (state == WALK) || (state == TRACE);
  assign mon.dl_detect     = detect_q;
  assign mon.dl_origin     = origin_q;
  assign mon.dl_cycle_mask = mask_q;
  assign mon.dl_cycle_len  = len_q;

  // ---------------------------------------------------------------------------
  // Watchdog: counts consecutive blocked cycles regardless of graph changes,
  // catching livelock and stalls on external I/O that form no cycle.
  // ---------------------------------------------------------------------------
`ifdef DL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] wd_cnt;
  logic            timeout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (mon.dl_clear) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (mon.proc_blk == '0) begin
      wd_cnt    <= '0;
    end else if (wd_cnt != TO_MAX) begin
      wd_cnt <= wd_cnt + TO_W'(1);
      if (wd_cnt == TO_MAX - TO_W'(1)) timeout_q <= 1'b1;
    end
  end

  assign mon.dl_timeout = timeout_q;
`else
  assign mon.dl_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// -----------------------------------------------------------------------------
// tb_dataflow_deadlock_monitor
//   Self-checking bench for dataflow_deadlock_monitor (N_PROC=3, ID_W=2,
//   STALL_CYCLES=4, TIMEOUT_CYCLES=64). Directed graph table, hand-written
//   multi-cycle sequences, and random graphs compared against a path-list
//   reference model.
// -----------------------------------------------------------------------------
module tb_dataflow_deadlock_monitor;
  localparam int N   = 3;
  localparam int IDW = 2;
  localparam int SC  = 4;
  localparam int TO  = 64;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dataflow_deadlock_monitor_if #(.N_PROC(N), .ID_W(IDW)) mon_if ();

  dataflow_deadlock_monitor #(
    .N_PROC(N), .ID_W(IDW), .STALL_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (mon_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drop every block, clear sticky results, let the monitor settle.
  task automatic quiesce();
    mon_if.proc_blk    = '0;
    mon_if.proc_dep_id = '0;
    mon_if.dl_clear    = 1'b1;
    tick(1);
    mon_if.dl_clear    = 1'b0;
    tick(2);
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (mon_if.busy) ok = 1'b1;
    end
  endtask

  task automatic wait_detect(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (mon_if.dl_detect) ok = 1'b1;
    end
  endtask

  // Reference: for each blocked start in ascending order, build the path as a
  // list; a dependency already on the list closes a cycle starting there.
  task automatic model(input  logic [N-1:0]     blk,
                       input  logic [N*IDW-1:0] dep,
                       output logic             det,
                       output logic [IDW-1:0]   org,
                       output logic [N-1:0]     mask,
                       output logic [IDW:0]     len);
    int path[$];
    int n;
    int d;
    int hit;
    bit stop;
    det = 1'b0; org = '0; mask = '0; len = '0;
    for (int s = 0; s < N; s++) begin
      if (blk[s] && !det) begin
        path.delete();
        path.push_back(s);
        n    = s;
        stop = 1'b0;
        while (!stop) begin
          d = int'(dep[n*IDW +: IDW]);
          if (!blk[n] || d >= N) begin
            stop = 1'b1;
          end else begin
            hit = -1;
            for (int k = 0; k < path.size(); k++)
              if (path[k] == d && hit < 0) hit = k;
            if (hit >= 0) begin
              det  = 1'b1;
              org  = IDW'(d);
              for (int k = hit; k < path.size(); k++) mask[path[k]] = 1'b1;
              len  = (IDW+1)'(path.size() - hit);
              stop = 1'b1;
            end else begin
              path.push_back(d);
              n = d;
            end
          end
        end
      end
    end
  endtask

  typedef struct {
    logic [N-1:0]     blk;
    logic [N*IDW-1:0] dep;   // {dep2, dep1, dep0}
    logic             det;
    logic [IDW-1:0]   org;
    logic [N-1:0]     mask;
    logic [IDW:0]     len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit               ok;
    int               busy_cnt;
    logic             e_det;
    logic [IDW-1:0]   e_org;
    logic [N-1:0]     e_mask;
    logic [IDW:0]     e_len;
    logic [N-1:0]     r_blk;
    logic [N*IDW-1:0] r_dep;

    vecs[0] = '{3'b111, 6'b00_10_01, 1'b1, 2'd0, 3'b111, 3'd3}; // ring 0->1->2->0
    vecs[1] = '{3'b111, 6'b01_10_01, 1'b1, 2'd1, 3'b110, 3'd2}; // tail into 1<->2
    vecs[2] = '{3'b011, 6'b00_10_01, 1'b0, 2'd0, 3'b000, 3'd0}; // chain to running 2
    vecs[3] = '{3'b100, 6'b10_00_00, 1'b1, 2'd2, 3'b100, 3'd1}; // self-loop 2
    vecs[4] = '{3'b111, 6'b11_11_11, 1'b0, 2'd0, 3'b000, 3'd0}; // all deps invalid
    vecs[5] = '{3'b011, 6'b00_00_01, 1'b1, 2'd0, 3'b011, 3'd2}; // 0<->1
    vecs[6] = '{3'b111, 6'b01_10_11, 1'b1, 2'd1, 3'b110, 3'd2}; // 0 dead, 1<->2

    // ---- reset state ----
    reset              = 1'b0;
    mon_if.proc_blk    = '0;
    mon_if.proc_dep_id = '0;
    mon_if.dl_clear    = 1'b0;
    #1;
    check("reset_busy",    32'(mon_if.busy),          0);
    check("reset_detect",  32'(mon_if.dl_detect),     0);
    check("reset_mask",    32'(mon_if.dl_cycle_mask), 0);
    check("reset_len",     32'(mon_if.dl_cycle_len),  0);
    check("reset_origin",  32'(mon_if.dl_origin),     0);
    check("reset_timeout", 32'(mon_if.dl_timeout),    0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // ---- directed table ----
    for (int v = 0; v < 7; v++) begin
      quiesce();
      mon_if.proc_blk    = vecs[v].blk;
      mon_if.proc_dep_id = vecs[v].dep;
      tick(40);
      check($sformatf("tbl%0d_detect", v), 32'(mon_if.dl_detect),     32'(vecs[v].det));
      check($sformatf("tbl%0d_origin", v), 32'(mon_if.dl_origin),     32'(vecs[v].org));
      check($sformatf("tbl%0d_mask",   v), 32'(mon_if.dl_cycle_mask), 32'(vecs[v].mask));
      check($sformatf("tbl%0d_len",    v), 32'(mon_if.dl_cycle_len),  32'(vecs[v].len));
      check($sformatf("tbl%0d_busy",   v), 32'(mon_if.busy),          0);
    end

    // ---- ring: busy window no longer than 7 cycles ----
    quiesce();
    mon_if.proc_blk    = 3'b111;
    mon_if.proc_dep_id = 6'b00_10_01;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (mon_if.busy) busy_cnt++;
    end
    check("ring_detect", 32'(mon_if.dl_detect), 1);
    check("ring_busy_window", 32'(busy_cnt >= 1 && busy_cnt <= 7), 1);

    // ---- chain: no re-walk while stable, dep change re-arms ----
    quiesce();
    mon_if.proc_blk    = 3'b011;
    mon_if.proc_dep_id = 6'b00_10_01;
    tick(30);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mon_if.busy) busy_cnt++;
    end
    check("chain_no_rewalk", 32'(busy_cnt), 0);
    mon_if.proc_dep_id = 6'b01_10_01;
    wait_busy(20, ok);
    check("chain_rearm_walk", 32'(ok), 1);
    tick(20);
    check("chain_detect", 32'(mon_if.dl_detect), 0);

    // ---- abort: proc_blk[1] drops on the 2nd WALK cycle ----
    quiesce();
    mon_if.proc_blk    = 3'b011;
    mon_if.proc_dep_id = 6'b00_00_01;
    wait_busy(20, ok);
    check("abort_walk_start", 32'(ok), 1);
    tick(1);
    mon_if.proc_blk = 3'b001;
    tick(1);
    check("abort_busy",      32'(mon_if.busy),      0);
    check("abort_detect",    32'(mon_if.dl_detect), 0);
    check("abort_stall_cnt", 32'(dut.stall_cnt),    0);
    tick(20);
    check("abort_detect_later", 32'(mon_if.dl_detect), 0);

    // ---- self-loop, clear, re-detect ----
    quiesce();
    mon_if.proc_blk    = 3'b100;
    mon_if.proc_dep_id = 6'b10_00_00;
    wait_detect(30, ok);
    check("self_detect", 32'(ok), 1);
    check("self_mask",   32'(mon_if.dl_cycle_mask), 3'b100);
    check("self_len",    32'(mon_if.dl_cycle_len),  1);
    check("self_origin", 32'(mon_if.dl_origin),     2);
    mon_if.dl_clear = 1'b1;
    tick(1);
    mon_if.dl_clear = 1'b0;
    check("clear_detect", 32'(mon_if.dl_detect),     0);
    check("clear_mask",   32'(mon_if.dl_cycle_mask), 0);
    check("clear_len",    32'(mon_if.dl_cycle_len),  0);
    check("clear_origin", 32'(mon_if.dl_origin),     0);
    wait_detect(30, ok);
    check("self_redetect", 32'(ok), 1);
    check("self_redetect_mask", 32'(mon_if.dl_cycle_mask), 3'b100);

    // ---- async reset in the middle of TRACE ----
    quiesce();
    mon_if.proc_blk    = 3'b111;
    mon_if.proc_dep_id = 6'b00_10_01;
    wait_busy(20, ok);
    check("trace_walk_start", 32'(ok), 1);
    tick(3);
    #2 reset = 1'b0;
    #1;
    check("midtrace_busy",   32'(mon_if.busy),          0);
    check("midtrace_detect", 32'(mon_if.dl_detect),     0);
    check("midtrace_mask",   32'(mon_if.dl_cycle_mask), 0);
    check("midtrace_len",    32'(mon_if.dl_cycle_len),  0);
    check("midtrace_origin", 32'(mon_if.dl_origin),     0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // ---- watchdog ----
    quiesce();
    mon_if.proc_blk    = 3'b001;
    mon_if.proc_dep_id = 6'b00_00_01;
    tick(50);
    check("wd_early", 32'(mon_if.dl_timeout), 0);
    tick(20);
`ifdef DL_TIMEOUT_EN
    check("wd_timeout", 32'(mon_if.dl_timeout), 1);
`else
    check("wd_timeout", 32'(mon_if.dl_timeout), 0);
`endif
    check("wd_detect", 32'(mon_if.dl_detect), 0);

    // ---- random graphs vs reference model ----
    for (int t = 0; t < 24; t++) begin
      quiesce();
      r_blk = N'($urandom_range(0, 7));
      r_dep = (N*IDW)'($urandom_range(0, 63));
      mon_if.proc_blk    = r_blk;
      mon_if.proc_dep_id = r_dep;
      tick(40);
      model(r_blk, r_dep, e_det, e_org, e_mask, e_len);
      check($sformatf("rnd%0d_detect", t), 32'(mon_if.dl_detect),     32'(e_det));
      check($sformatf("rnd%0d_origin", t), 32'(mon_if.dl_origin),     32'(e_org));
      check($sformatf("rnd%0d_mask",   t), 32'(mon_if.dl_cycle_mask), 32'(e_mask));
      check($sformatf("rnd%0d_len",    t), 32'(mon_if.dl_cycle_len),  32'(e_len));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
